// File: rtl/rom_loader_pkg.sv
// Shared types for the SDRAM write-port loader: the packed word that travels
// from the byte packer through the FIFO to the port, and the initiator states.
package sdram_pkg;

   typedef struct packed {
      logic [22:0] wa;
      logic [15:0] d;
      logic [1:0]  ds;
   } port_word_t;

   typedef enum logic {
      IDLE,
      WAIT
   } ldr_state_e;

   // Builds a fresh single-byte word: odd addresses land in the upper lane,
   // even addresses in the lower lane, the other lane stays zero and disabled.
   function automatic port_word_t placeByte(input logic [22:0] wa,
                                            input logic        odd,
                                            input logic [7:0]  b);
      port_word_t w;
      w.wa = wa;
      if (odd) begin
         w.d  = {b, 8'h00};
         w.ds = 2'b10;
      end else begin
         w.d  = {8'h00, b};
         w.ds = 2'b01;
      end
      return w;
   endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Toggle-handshake write port towards one SDRAM controller port. The loader
// is the master; the controller (or its port mux) is the slave.
interface rom_loader_if;

   logic        port_req;
   logic        port_ack;
   logic        port_we;
   logic [22:0] port_a;
   logic [1:0]  port_ds;
   logic [15:0] port_d;

   modport master (
      output port_req,
      input  port_ack,
      output port_we,
      output port_a,
      output port_ds,
      output port_d
   );

   modport slave (
      input  port_req,
      output port_ack,
      input  port_we,
      input  port_a,
      input  port_ds,
      input  port_d
   );

endinterface

// File: rtl/rom_loader_fifo.sv
// Small synchronous FIFO of packed port words. Pointers carry one extra wrap
// bit so full and empty can be told apart. A push that coincides with a pop
// is accepted even when the FIFO is full; a push that cannot be stored is
// reported on drop_o.
module word_fifo
   import sdram_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       init_n,
   input  logic       push_i,
   input  port_word_t pushData_i,
   input  logic       pop_i,
   output port_word_t head_o,
   output logic       full_o,
   output logic       empty_o,
   output logic       drop_o
);

   localparam int AW = $clog2(DEPTH);

   port_word_t     mem_q [DEPTH];
   logic [AW:0]    wrPtr_q;
   logic [AW:0]    rdPtr_q;
   logic           doPop;
   logic           doPush;

   assign empty_o = (wrPtr_q == rdPtr_q);
   assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                    (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign doPop   = pop_i && !empty_o;
   assign doPush  = push_i && (!full_o || doPop);
   assign drop_o  = push_i && !doPush;
   assign head_o  = mem_q[rdPtr_q[AW-1:0]];

   // Advance read and write pointers on accepted pops and pushes.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
      end
   end

endmodule

// File: rtl/rom_loader.sv
// Download-to-SDRAM write initiator. Packs ioctl bytes into 16-bit words with
// byte enables, buffers them in a small FIFO and issues one toggle-handshake
// write per word. The port is only in use while a download runs or words are
// still on their way out.
module rom_loader
   import sdram_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [22:0] BASE_WA    = 23'd0
) (
   input  logic          clk,
   input  logic          init_n,
   input  logic          ioctl_downl,
   input  logic          ioctl_wr,
   input  logic [24:0]   ioctl_addr,
   input  logic [7:0]    ioctl_dout,
   rom_loader_if.master  port,
   output logic          busy,
   output logic          overflow
);

   ldr_state_e  state_q;
   logic        req_q;
   logic        we_q;
   logic [22:0] a_q;
   logic [15:0] d_q;
   logic [1:0]  ds_q;

   logic        downl_q;
   logic        pendValid_q;
   logic        pendValid_d;
   port_word_t  pend_q;
   port_word_t  pend_d;
   logic        overflow_q;
   logic        busy_q;

   logic        byteAcc;
   logic        byteOdd;
   logic [22:0] byteWa;
   logic        downlFall;
   logic        downlRise;
   port_word_t  merged;
   logic        push;
   port_word_t  pushWord;

   logic        fifoPop;
   port_word_t  fifoHead;
   logic        fifoFull;
   logic        fifoEmpty;
   logic        fifoDrop;

   logic        unusedAddrBit;

   assign unusedAddrBit = ioctl_addr[24];

   assign byteAcc   = ioctl_downl && ioctl_wr;
   assign byteOdd   = ioctl_addr[0];
   assign byteWa    = ioctl_addr[23:1] + BASE_WA;
   assign downlFall = downl_q && !ioctl_downl;
   assign downlRise = !downl_q && ioctl_downl;

   // Byte packer: merge into the pending word or retire it, and decide the
   // single FIFO push for this cycle.
   always_comb begin
      pendValid_d = pendValid_q;
      pend_d      = pend_q;
      push        = 1'b0;
      pushWord    = pend_q;
      merged      = pend_q;
      if (byteAcc) begin
         if (pendValid_q && (pend_q.wa == byteWa)) begin
            if (byteOdd) begin
               merged.d[15:8] = ioctl_dout;
               merged.ds[1]   = 1'b1;
            end else begin
               merged.d[7:0]  = ioctl_dout;
               merged.ds[0]   = 1'b1;
            end
            if (merged.ds == 2'b11) begin
               push        = 1'b1;
               pushWord    = merged;
               pendValid_d = 1'b0;
            end else begin
               pend_d = merged;
            end
         end else begin
            push        = pendValid_q;
            pushWord    = pend_q;
            pendValid_d = 1'b1;
            pend_d      = placeByte(byteWa, byteOdd, ioctl_dout);
         end
      end else if (downlFall && pendValid_q) begin
         push        = 1'b1;
         pushWord    = pend_q;
         pendValid_d = 1'b0;
      end
   end

   assign fifoPop = (state_q == IDLE) && !fifoEmpty;

   word_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .init_n    (init_n),
      .push_i    (push),
      .pushData_i(pushWord),
      .pop_i     (fifoPop),
      .head_o    (fifoHead),
      .full_o    (fifoFull),
      .empty_o   (fifoEmpty),
      .drop_o    (fifoDrop)
   );

   // Packer state, download edge tracker, sticky overflow and registered busy.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         downl_q     <= 1'b0;
         pendValid_q <= 1'b0;
         pend_q      <= '0;
         overflow_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         downl_q     <= ioctl_downl;
         pendValid_q <= pendValid_d;
         pend_q      <= pend_d;
         if (downlRise) begin
            overflow_q <= 1'b0;
         end
         if (fifoDrop) begin
            overflow_q <= 1'b1;
         end
         busy_q <= ioctl_downl || !fifoEmpty || pendValid_q ||
                   (state_q == WAIT) || (req_q != port.port_ack);
      end
   end

   // Initiator: pop a word and toggle req from IDLE, wait for ack to match.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         a_q     <= '0;
         d_q     <= '0;
         ds_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifoEmpty) begin
                  a_q     <= fifoHead.wa;
                  d_q     <= fifoHead.d;
                  ds_q    <= fifoHead.ds;
                  we_q    <= 1'b1;
                  req_q   <= ~req_q;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (port.port_ack == req_q) begin
                  we_q    <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign port.port_req = req_q;
   assign port.port_we  = we_q;
   assign port.port_a   = a_q;
   assign port.port_d   = d_q;
   assign port.port_ds  = ds_q;
   assign busy          = busy_q;
   assign overflow      = overflow_q;

endmodule
